json_char_feeder: RTL

Upstream stage of the json key-value counter. It buffers a bursty byte stream from a valid/ready source and drains it one byte per cycle onto the counter's 8-bit char input. The counter treats 8'h00 as idle, so this block drives 8'h00 whenever it has nothing to send. Optionally strips JSON whitespace outside string literals; a quote/escape FSM decides what counts as outside a string.

---
 rtl/json_char_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/json_char_feeder.sv
// json_char_feeder
//   Front end of the json key-value counter. Buffers a bursty valid/ready
//   byte stream in a small FIFO and drains it one byte per cycle onto the
//   counter's char input. 8'h00 is the counter's idle code, so it is driven
//   whenever nothing is being sent. Optionally drops JSON whitespace that
//   lies outside string literals, as tracked by a quote/escape FSM.
//
// Ports
//   clk        : clock, all state updates on posedge
//   reset      : synchronous active-high reset
//   in_char    : source byte
//   in_valid   : source byte present
//   in_ready   : a byte can be accepted this cycle (combinational)
//   strip_ws   : 1 = drop whitespace outside strings, sampled per accepted byte
//   out_en     : downstream enable, 0 stalls draining
//   char       : byte to the counter, 8'h00 when idle
//   char_valid : char holds a real byte this cycle
//   count      : FIFO occupancy, 0..DEPTH
//   in_string  : quote FSM is inside a string (or its escape)
//   overflow   : sticky, a byte was offered while full
module json_char_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_char,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              strip_ws,
  input  logic              out_en,
  output logic [7:0]        char,
  output logic              char_valid,
  output logic [ADDR_W:0]   count,
  output logic              in_string,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_OUT    = 2'd0,
    S_IN_STR = 2'd1,
    S_IN_ESC = 2'd2
  } qstate_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  qstate_t           state;
  qstate_t           state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              accept;
  logic              store;
  logic              drain;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  assign in_ready  = !reset && (count != FULL_CNT);
  assign accept    = in_valid && in_ready;
  // The filter looks at the FSM state before this byte, so an opening quote
  // is judged as "outside" and a closing quote as "inside".
  assign store     = accept && (in_char != 8'h00) &&
                     !(strip_ws && (state == S_OUT) && is_ws(in_char));
  assign drain     = out_en && (count != '0);
  assign in_string = (state != S_OUT);

  // Quote/escape FSM: advances on every accepted byte, stored or dropped
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_OUT:    if (in_char == 8'h22) state_nxt = S_IN_STR;
        S_IN_STR: begin
          if (in_char == 8'h5C)      state_nxt = S_IN_ESC;
          else if (in_char == 8'h22) state_nxt = S_OUT;
        end
        S_IN_ESC: state_nxt = S_IN_STR;
        default:  state_nxt = S_OUT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_OUT;
    else       state <= state_nxt;
  end

  // Input stage: FIFO storage (data only, not reset)
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_char;
  end

  // FIFO control and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      char       <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      case ({store, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (drain) begin
        char       <= mem[rd_ptr];
        char_valid <= 1'b1;
      end else begin
        char       <= 8'h00;
        char_valid <= 1'b0;
      end
    end
  end

endmodule
